gcd_requester: RTL and testbench

Initiator-side sequencer for the GCD engine. Accepts operand pairs from an upstream valid/ready stream and issues each pair to the GCD engine over a four-phase req/ack handshake. Captures and sanity-checks the returned divisor, then presents operands, result and an error flag on a downstream valid/ready stream. Zero operands are answered locally, and a missing acknowledge ends in a bounded timeout.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_req_timer.sv | 36 +++
 rtl/gcd_requester.sv | 157 +++++++++++++++
 tb/tb_gcd_requester.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester and the GCD engine it drives.
package gcd_pkg;

  localparam int GCD_WIDTH   = 4;
  localparam int GCD_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } gcd_req_state_t;

endpackage

// File: rtl/gcd_req_timer.sv
// Saturating cycle counter for the request phase; hit flags the last cycle
// a request may stay outstanding.
module gcd_req_timer
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TOP  = TW'(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_r;

  // Count enabled cycles, holding at TOP instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable && (count_r != TOP)) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == LAST);

endmodule

// File: rtl/gcd_requester.sv
// Initiator-side sequencer: takes operand pairs, runs a four-phase req/ack
// exchange with the GCD engine, checks the divisor and returns the result.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             gcd_req,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  input  logic             gcd_ack,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  // A divisor of two nonzero operands can be neither zero nor larger than the smaller one.
  function automatic logic result_bad(input logic [WIDTH-1:0] r,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] lo;
    lo = (a < b) ? a : b;
    return (r == ZERO) || (r > lo);
  endfunction

  gcd_req_state_t   state_r, state_s;
  logic             in_ready_r, gcd_req_r, out_valid_r, out_err_r;
  logic [WIDTH-1:0] gcd_x_r, gcd_y_r, out_x_r, out_y_r, out_gcd_r;
  logic [WIDTH-1:0] gcd_x_s, gcd_y_s, out_x_s, out_y_s, out_gcd_s;
  logic             out_err_s;
  logic             timer_clear_s, timer_enable_s, timer_hit_s;

  assign timer_clear_s  = (state_r == IDLE);
  assign timer_enable_s = (state_r == REQ);

  gcd_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_s),
    .enable (timer_enable_s),
    .hit    (timer_hit_s)
  );

  // Next state and next values of the operand/result registers.
  always_comb begin
    state_s   = state_r;
    gcd_x_s   = gcd_x_r;
    gcd_y_s   = gcd_y_r;
    out_x_s   = out_x_r;
    out_y_s   = out_y_r;
    out_gcd_s = out_gcd_r;
    out_err_s = out_err_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          out_x_s = in_x;
          out_y_s = in_y;
          if ((in_x == ZERO) || (in_y == ZERO)) begin
            out_gcd_s = in_x | in_y;
            out_err_s = 1'b0;
            state_s   = RESP;
          end else begin
            gcd_x_s = in_x;
            gcd_y_s = in_y;
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // An ack on the final timer cycle takes priority over the timeout.
        if (gcd_ack) begin
          out_gcd_s = gcd_result;
          out_err_s = result_bad(gcd_result, out_x_r, out_y_r);
          state_s   = RELEASE;
        end else if (timer_hit_s) begin
          out_gcd_s = ZERO;
          out_err_s = 1'b1;
          state_s   = RELEASE;
        end else begin
          state_s = REQ;
        end
      end
      RELEASE: begin
        if (!gcd_ack) begin
          state_s = RESP;
        end else begin
          state_s = RELEASE;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; the handshake flags follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      gcd_req_r   <= 1'b0;
      out_valid_r <= 1'b0;
      gcd_x_r     <= ZERO;
      gcd_y_r     <= ZERO;
      out_x_r     <= ZERO;
      out_y_r     <= ZERO;
      out_gcd_r   <= ZERO;
      out_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      gcd_req_r   <= (state_s == REQ);
      out_valid_r <= (state_s == RESP);
      gcd_x_r     <= gcd_x_s;
      gcd_y_r     <= gcd_y_s;
      out_x_r     <= out_x_s;
      out_y_r     <= out_y_s;
      out_gcd_r   <= out_gcd_s;
      out_err_r   <= out_err_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign gcd_req   = gcd_req_r;
  assign gcd_x     = gcd_x_r;
  assign gcd_y     = gcd_y_r;
  assign out_valid = out_valid_r;
  assign out_x     = out_x_r;
  assign out_y     = out_y_r;
  assign out_gcd   = out_gcd_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: directed table, reset corner case and
// randomized operations against a behavioural engine/requester model.
module tb_gcd_requester;

  localparam int W  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = 4'd0, in_y = 4'd0;
  logic         gcd_req;
  logic [W-1:0] gcd_x, gcd_y;
  logic         gcd_ack = 1'b0;
  logic [W-1:0] gcd_result = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_x, out_y, out_gcd;
  logic         out_err;

  int vectors = 0;
  int miscompares = 0;

  gcd_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .gcd_req(gcd_req), .gcd_x(gcd_x), .gcd_y(gcd_y),
    .gcd_ack(gcd_ack), .gcd_result(gcd_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_gcd(out_gcd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           d;       // cycle after accept in which the engine raises ack
    logic [W-1:0] res;
    int           hold;    // number of cycles ack stays high
    int           rdy;     // cycles out_ready stays low once out_valid is up
    logic [W-1:0] exp_gcd;
    logic         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // What the requester must report for one operation.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input int d,
                                input logic [W-1:0] res, output logic [W-1:0] g, output logic e);
    int lo;
    if (x == 0 || y == 0) begin
      g = x | y;
      e = 1'b0;
    end else if (d <= TO) begin
      lo = (x < y) ? int'(x) : int'(y);
      g  = res;
      e  = (res == 0) || (int'(res) > lo);
    end else begin
      g = 4'd0;
      e = 1'b1;
    end
  endfunction

  // Cycle (counted from the accept edge) in which out_valid first reads high.
  function automatic int valid_cycle(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input int d, input int hold);
    int c;
    if (x == 0 || y == 0) return 1;
    c = (d <= TO) ? d + 1 : TO + 1;
    while (c >= d && c < d + hold) c++;
    return c + 1;
  endfunction

  function automatic int req_cycles(input logic [W-1:0] x, input logic [W-1:0] y, input int d);
    if (x == 0 || y == 0) return 0;
    return (d <= TO) ? d : TO;
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int d,
                        input logic [W-1:0] res, input int hold, input int rdy,
                        input logic [W-1:0] eg, input logic ee);
    int k;
    int nreq;
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    wait_clk();
    in_valid = 1'b0;
    in_x = 4'd0;
    in_y = 4'd0;
    check("in_ready_busy", in_ready, 0);
    k = 1;
    nreq = 0;
    while (!out_valid && k <= 60) begin
      if (gcd_req) begin
        nreq++;
        check("gcd_x_stable", gcd_x, x);
        check("gcd_y_stable", gcd_y, y);
      end
      gcd_ack = (k >= d) && (k < d + hold);
      gcd_result = res;
      wait_clk();
      k++;
    end
    check("out_valid_seen", out_valid, 1);
    check("valid_latency", k, valid_cycle(x, y, d, hold));
    check("req_cycle_count", nreq, req_cycles(x, y, d));
    check("out_x", out_x, x);
    check("out_y", out_y, y);
    check("out_gcd", out_gcd, eg);
    check("out_err", out_err, ee);
    for (int i = 0; i < rdy; i++) begin
      gcd_ack = (k >= d) && (k < d + hold);
      wait_clk();
      k++;
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_req", gcd_req, 0);
      check("stall_out_x", out_x, x);
      check("stall_out_y", out_y, y);
      check("stall_gcd", out_gcd, eg);
      check("stall_err", out_err, ee);
    end
    gcd_ack = (k >= d) && (k < d + hold);
    out_ready = 1'b1;
    wait_clk();
    out_ready = 1'b0;
    gcd_ack = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_after_resp", in_ready, 1);
  endtask

  vec_t tbl[12];

  initial begin
    logic [W-1:0] rx, ry, rres, eg;
    logic ee;
    int rd, rh, rr;

    tbl[0]  = '{4'd12, 4'd8,  2,    4'd4,  1, 0, 4'd4,  1'b0};
    tbl[1]  = '{4'd0,  4'd9,  1000, 4'd0,  0, 0, 4'd9,  1'b0};
    tbl[2]  = '{4'd0,  4'd0,  1000, 4'd0,  0, 0, 4'd0,  1'b0};
    tbl[3]  = '{4'd6,  4'd9,  1000, 4'd3,  1, 0, 4'd0,  1'b1};
    tbl[4]  = '{4'd6,  4'd9,  20,   4'd5,  3, 8, 4'd0,  1'b1};
    tbl[5]  = '{4'd6,  4'd9,  16,   4'd3,  3, 0, 4'd0,  1'b1};
    tbl[6]  = '{4'd6,  4'd9,  15,   4'd3,  1, 0, 4'd3,  1'b0};
    tbl[7]  = '{4'd10, 4'd15, 1,    4'd11, 1, 0, 4'd11, 1'b1};
    tbl[8]  = '{4'd10, 4'd15, 3,    4'd0,  2, 0, 4'd0,  1'b1};
    tbl[9]  = '{4'd15, 4'd15, 1,    4'd15, 2, 1, 4'd15, 1'b0};
    tbl[10] = '{4'd15, 4'd5,  4,    4'd6,  1, 2, 4'd6,  1'b1};
    tbl[11] = '{4'd9,  4'd0,  1000, 4'd0,  0, 0, 4'd9,  1'b0};

    // Reset values while reset is held low.
    wait_clk();
    wait_clk();
    check("rst_in_ready", in_ready, 1);
    check("rst_gcd_req", gcd_req, 0);
    check("rst_gcd_x", gcd_x, 0);
    check("rst_gcd_y", gcd_y, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_x", out_x, 0);
    reset = 1'b1;
    wait_clk();

    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].res, tbl[i].hold, tbl[i].rdy,
             tbl[i].exp_gcd, tbl[i].exp_err);
    end

    // Reset pulled low in the middle of a request.
    in_valid = 1'b1;
    in_x = 4'd5;
    in_y = 4'd10;
    wait_clk();
    in_valid = 1'b0;
    wait_clk();
    wait_clk();
    check("midop_req_high", gcd_req, 1);
    reset = 1'b0;
    #1;
    check("midop_rst_req", gcd_req, 0);
    check("midop_rst_valid", out_valid, 0);
    check("midop_rst_in_ready", in_ready, 1);
    check("midop_rst_out_x", out_x, 0);
    check("midop_rst_gcd_x", gcd_x, 0);
    wait_clk();
    reset = 1'b1;
    wait_clk();
    wait_clk();
    check("post_rst_no_req", gcd_req, 0);
    check("post_rst_no_valid", out_valid, 0);
    run_op(4'd9, 4'd6, 1, 4'd3, 1, 5, 4'd3, 1'b0);

    // Randomized operations against the model.
    for (int n = 0; n < 30; n++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rx = 4'd0;
      rd = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(1, TO + 1));
      rh = int'($urandom_range(1, 3));
      rr = int'($urandom_range(0, 3));
      rres = ($urandom_range(0, 1) == 1) ? 4'(ref_gcd(int'(rx), int'(ry)))
                                         : 4'($urandom_range(0, 15));
      model(rx, ry, rd, rres, eg, ee);
      run_op(rx, ry, rd, rres, rh, rr, eg, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
